// File: rtl/mod_counter_pkg.sv
// Shared types and defaults for the modulo-N up/down counter.
package mod_counter_pkg;

  // Behaviour when a step would leave the 0..MODULUS-1 range.
  typedef enum logic {
    MODE_WRAP     = 1'b0,
    MODE_SATURATE = 1'b1
  } mode_e;

  localparam int DEF_WIDTH   = 6;
  localparam int DEF_MODULUS = 16;

endpackage

// File: rtl/mod_counter_updown_if.sv
// Control/status bundle of the modulo-N up/down counter.
// master drives the controls, slave is the counter itself.
interface mod_counter_updown_if #(
  parameter int WIDTH = mod_counter_pkg::DEF_WIDTH
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_flags;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrapped;

  modport master (
    output en, up, load, load_val, clr_flags,
    input  count, tc, wrapped
  );

  modport slave (
    input  en, up, load, load_val, clr_flags,
    output count, tc, wrapped
  );
endinterface

// File: rtl/mod_counter_step.sv
// Combinational next-value logic for one enabled step of the counter.
// Compares in WIDTH+1 bits so MODULUS == 2**WIDTH needs no special case.
module mod_counter_step
  import mod_counter_pkg::*;
#(
  parameter int    WIDTH   = DEF_WIDTH,
  parameter int    MODULUS = DEF_MODULUS,
  parameter mode_e MODE    = MODE_WRAP
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_next_count,
  output logic             o_limit_evt
);

  localparam int         LAST_I = MODULUS - 1;
  localparam logic [WIDTH:0] LAST = LAST_I[WIDTH:0];

  logic [WIDTH:0] w_cnt_ext;

  // Step one position in the requested direction; flag and resolve the limit.
  always_comb begin
    w_cnt_ext    = {1'b0, i_count};
    o_next_count = i_count;
    o_limit_evt  = 1'b0;
    if (i_up) begin
      if (w_cnt_ext < LAST) begin
        o_next_count = i_count + 1'b1;
      end else begin
        o_limit_evt = 1'b1;
        if (MODE == MODE_WRAP) o_next_count = '0;
      end
    end else begin
      if (i_count != '0) begin
        o_next_count = i_count - 1'b1;
      end else begin
        o_limit_evt = 1'b1;
        if (MODE == MODE_WRAP) o_next_count = LAST[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/mod_counter_updown.sv
// Parametrised modulo-N up/down counter with load, wrap/saturate mode,
// registered terminal-count pulse and sticky wrapped flag.
// Optional macro MOD_COUNTER_FORMAL_EN compiles in embedded assertions.
module mod_counter_updown
  import mod_counter_pkg::*;
#(
  parameter int    WIDTH   = DEF_WIDTH,
  parameter int    MODULUS = DEF_MODULUS,
  parameter mode_e MODE    = MODE_WRAP
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_counter_updown_if.slave  bus
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_counter_updown: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam int             LAST_I  = MODULUS - 1;
  localparam logic [WIDTH:0] LAST    = LAST_I[WIDTH:0];
  localparam logic [WIDTH:0] MOD_EXT = MODULUS[WIDTH:0];

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_wrapped;

  logic [WIDTH-1:0] w_next;
  logic             w_limit;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_evt;

  mod_counter_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .MODE    (MODE)
  ) u_step (
    .i_count      (r_count),
    .i_up         (bus.up),
    .o_next_count (w_next),
    .o_limit_evt  (w_limit)
  );

  // Out-of-range load values clamp to the top of the range; a limit event
  // only counts when a step actually happens (load has priority over en).
  always_comb begin
    w_load_clamped = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val : LAST[WIDTH-1:0];
    w_evt          = bus.en & ~bus.load & w_limit;
  end

  // Count, terminal-count pulse and sticky flag; priority rst > load > en.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_tc      <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      if (bus.load) begin
        r_count <= w_load_clamped;
        r_tc    <= 1'b0;
      end else if (bus.en) begin
        r_count <= w_next;
        r_tc    <= w_limit;
      end else begin
        r_tc    <= 1'b0;
      end
      // A new event beats a simultaneous clear.
      if (w_evt)              r_wrapped <= 1'b1;
      else if (bus.clr_flags) r_wrapped <= 1'b0;
    end
  end

  assign bus.count   = r_count;
  assign bus.tc      = r_tc;
  assign bus.wrapped = r_wrapped;

`ifdef MOD_COUNTER_FORMAL_EN
  initial r_count = '0;

  logic r_past_vld;
  initial r_past_vld = 1'b0;

  // Marks that $past() values refer to a real previous cycle.
  always_ff @(posedge clk) r_past_vld <= 1'b1;

  // The step logic must never propose an out-of-range value.
  always_comb begin
    assert ({1'b0, w_next} < MOD_EXT);
  end

  a_range : assert property (@(posedge clk) ({1'b0, r_count} < MOD_EXT));

  a_reset : assert property (@(posedge clk)
    r_past_vld && $past(rst) |-> (r_count == '0) && !r_tc && !r_wrapped);

  a_up : assert property (@(posedge clk)
    r_past_vld && $past(bus.en && bus.up && !bus.load && !rst && ({1'b0, r_count} < LAST))
    |-> r_count == $past(r_count) + 1'b1);

  a_down : assert property (@(posedge clk)
    r_past_vld && $past(bus.en && !bus.up && !bus.load && !rst && (r_count != '0))
    |-> r_count == $past(r_count) - 1'b1);

  a_hold : assert property (@(posedge clk)
    r_past_vld && $past(!bus.en && !bus.load && !rst) |-> r_count == $past(r_count));

  a_tc_flag : assert property (@(posedge clk) r_tc |-> r_wrapped);

  if (MODE == MODE_SATURATE) begin : g_sat_chk
    a_sat_hold : assert property (@(posedge clk)
      r_past_vld && $past(bus.en && !bus.load && !rst && w_limit)
      |-> r_count == $past(r_count));
  end
`endif

endmodule

// File: tb/tb_mod_counter_updown.sv
// Scoreboard bench for mod_counter_updown: three instances (WRAP/16,
// SATURATE/16, WRAP/64) share one stimulus stream; a behavioural model
// pushes expected outputs, a monitor pops and compares after each edge.
module tb_mod_counter_updown;
  import mod_counter_pkg::*;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_counter_updown_if #(.WIDTH(6)) bus0 ();
  mod_counter_updown_if #(.WIDTH(6)) bus1 ();
  mod_counter_updown_if #(.WIDTH(6)) bus2 ();

  mod_counter_updown #(.WIDTH(6), .MODULUS(16), .MODE(MODE_WRAP)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  mod_counter_updown #(.WIDTH(6), .MODULUS(16), .MODE(MODE_SATURATE)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  mod_counter_updown #(.WIDTH(6), .MODULUS(64), .MODE(MODE_WRAP)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  int mods[NDUT] = '{16, 16, 64};
  bit sat [NDUT] = '{1'b0, 1'b1, 1'b0};

  int m_cnt[NDUT];
  bit m_tc [NDUT];
  bit m_wr [NDUT];

  typedef struct {
    int k;
    int cnt;
    bit tc;
    bit wr;
  } exp_t;
  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference behaviour: plain integer arithmetic on the counter range.
  task automatic model(input bit r, input bit l, input int lv, input bit e, input bit u, input bit c);
    for (int k = 0; k < NDUT; k++) begin
      bit evt;
      evt = 1'b0;
      if (r) begin
        m_cnt[k] = 0; m_tc[k] = 1'b0; m_wr[k] = 1'b0;
      end else begin
        if (l) begin
          m_cnt[k] = (lv < mods[k]) ? lv : mods[k] - 1;
          m_tc[k]  = 1'b0;
        end else if (e) begin
          if (u) begin
            evt = (m_cnt[k] == mods[k] - 1);
            if (!(evt && sat[k])) m_cnt[k] = (m_cnt[k] + 1) % mods[k];
          end else begin
            evt = (m_cnt[k] == 0);
            if (!(evt && sat[k])) m_cnt[k] = (m_cnt[k] + mods[k] - 1) % mods[k];
          end
          m_tc[k] = evt;
        end else begin
          m_tc[k] = 1'b0;
        end
        if (evt)    m_wr[k] = 1'b1;
        else if (c) m_wr[k] = 1'b0;
      end
      sb_q.push_back('{k: k, cnt: m_cnt[k], tc: m_tc[k], wr: m_wr[k]});
    end
  endtask

  task automatic drive_bus(input bit l, input int lv, input bit e, input bit u, input bit c);
    bus0.load = l; bus0.load_val = 6'(lv); bus0.en = e; bus0.up = u; bus0.clr_flags = c;
    bus1.load = l; bus1.load_val = 6'(lv); bus1.en = e; bus1.up = u; bus1.clr_flags = c;
    bus2.load = l; bus2.load_val = 6'(lv); bus2.en = e; bus2.up = u; bus2.clr_flags = c;
  endtask

  task automatic step(input bit r, input bit l, input int lv, input bit e, input bit u, input bit c);
    @(negedge clk);
    rst = r;
    drive_bus(l, lv, e, u, c);
    model(r, l, lv, e, u, c);
  endtask

  // Monitor: everything queued before an edge is due right after it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
        exp_t x;
        logic [5:0] a_cnt;
        logic       a_tc;
        logic       a_wr;
        x = sb_q.pop_front();
        case (x.k)
          0:       begin a_cnt = bus0.count; a_tc = bus0.tc; a_wr = bus0.wrapped; end
          1:       begin a_cnt = bus1.count; a_tc = bus1.tc; a_wr = bus1.wrapped; end
          default: begin a_cnt = bus2.count; a_tc = bus2.tc; a_wr = bus2.wrapped; end
        endcase
        chk("count",   x.k, {26'd0, a_cnt}, x.cnt);
        chk("tc",      x.k, {31'd0, a_tc},  int'(x.tc));
        chk("wrapped", x.k, {31'd0, a_wr},  int'(x.wr));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dir;
    for (int k = 0; k < NDUT; k++) begin
      m_cnt[k] = 0; m_tc[k] = 1'b0; m_wr[k] = 1'b0;
    end
    drive_bus(1'b0, 0, 1'b0, 1'b0, 1'b0);

    // reset beats load and en
    step(1, 1, 7, 1, 1, 0);
    // count up through the wrap
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 1, 0);
    // load 0, step down across zero, then clear flag with no event
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    // saturate at the top
    step(0, 1, 14, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0);
    // clamp and load-over-en
    step(0, 1, 40, 0, 0, 0);
    step(0, 1, 3, 1, 1, 0);
    // full-range modulus wrap from 63
    step(0, 1, 63, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    // clear and event in the same cycle: set wins
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    // reset mid-count with en and load high
    step(0, 0, 0, 1, 1, 0);
    step(1, 1, 5, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);

    // randomized phase with direction runs so limits are reached often
    dir = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bit r, l, e, c;
      int lv;
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      r  = ($urandom_range(0, 99) == 0);
      l  = ($urandom_range(0, 11) == 0);
      lv = int'($urandom_range(0, 63));
      e  = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 7) == 0);
      step(r, l, lv, e, dir, c);
    end

    @(negedge clk);
    drive_bus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
